// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with Mealy match output.
// Build with SEQDET_MATCH_COUNT_EN defined to include the saturating match counter.
module seq_detect_param #(
   parameter int                 PAT_W   = 4,
   parameter logic [PAT_W-1:0]   PAT_RST = 4'b1101,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int FW = $clog2(PAT_W);
   localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

   logic [PAT_W-1:0] pat;
   logic [PAT_W-2:0] hist;
   logic [PAT_W-2:0] hist_nxt;
   logic [FW-1:0]    fill;

   generate
      if (PAT_W == 2) begin : g_w2
         assign hist_nxt = in;
      end else begin : g_wn
         assign hist_nxt = {hist[PAT_W-3:0], in};
      end
   endgenerate

   assign match = in_valid & ~pat_load & (fill == FULL)
                & ({hist, in} == pat);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat  <= PAT_RST;
         hist <= '0;
         fill <= '0;
      end else if (pat_load) begin
         pat  <= pat_in;
         hist <= '0;
         fill <= '0;
      end else if (in_valid) begin
         hist <= hist_nxt;
         // Non-overlap restarts the window so no matched bit is reused
         if (match && !overlap)
            fill <= '0;
         else if (fill != FULL)
            fill <= fill + FW'(1);
      end
   end

`ifdef SEQDET_MATCH_COUNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (cnt_clr)
         cnt <= '0;
      else if (match && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + CNT_W'(1);
   end

   assign match_cnt = cnt;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
`endif

endmodule
